maxpool_2x2_stream: RTL and testbench
=====================================

# maxpool_2x2_stream

Streaming 2x2, stride-2 max-pool stage that sits directly downstream of the convolution engine. It consumes the 26x26 feature map one signed sample per accepted cycle in raster order and emits the 13x13 pooled map in raster order. A one-row line buffer holds the partial maxima for the current output row. An optional ReLU is applied to each pooled result.

## Interface
- DIM, 26, input feature-map width and height; must be even and ≥2.
- W, 20, sample width; two's-complement signed.
- CW, $clog2(DIM/2), output coordinate width (4 for the default).

- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to begin a frame; honoured only in IDLE.
- in_valid  in  1  in_data is a valid conv sample this cycle.
- in_data  in  W  signed conv sample.
- out_valid  out  1  one-cycle strobe; out_data/out_row/out_col valid.
- out_data  out  W  pooled (optionally ReLU'd) value.
- out_row  out  CW  output row index, 0..DIM/2-1.
- out_col  out  CW  output column index, 0..DIM/2-1.
- frame_done  out  1  one-cycle pulse coincident with the last out_valid of a frame.
- busy  out  1  high in RUN and DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_valid is ignored. If start is high, go to RUN and clear row and column counters r and c.
  - RUN: each in_valid cycle accepts one sample at (r,c). c increments and wraps at DIM-1 to 0, incrementing r. Accepting (DIM-1,DIM-1) moves to DONE.
  - DONE: lasts one cycle, then IDLE.
- start is ignored in RUN and DONE.
- Datapath, where x is the accepted sample, h is the hold register, and lb[0..DIM/2-1] is the line buffer (W bits each):
  - r even, c even: h ← x.
  - r even, c odd: lb[c/2] ← smax(h,x).
  - r odd, c even: h ← smax(lb[c/2], x).
  - r odd, c odd: result ← smax(h,x). It is registered to out_data with out_row=r/2 and out_col=(c-1)/2, and out_valid pulses.
- smax is a signed comparison. When the values are equal, either operand may be returned; the value is the same.
- No backpressure. The upstream gaps in in_valid are arbitrary, and state holds through the gaps.
- lb and h are not reset. Row-0 writes define lb before any read.
- out_data, out_row and out_col hold their last values between strobes.

## Timing
- Reset values: out_valid=0, out_data=0, out_row=0, out_col=0, frame_done=0, busy=0, state IDLE, r=c=0.
- Latency: out_valid is high in the cycle after the clock edge that accepts an odd-row, odd-column sample (1 cycle).
- Counts: exactly DIM*DIM accepted samples and (DIM/2)² outputs per frame, which is 676 and 169 by default.
- frame_done and the final out_valid (row 12, col 12) occur in the same cycle, which is the cycle the FSM is in DONE.
- Earliest next frame: start is honoured on the cycle after DONE. Back-to-back frames therefore lose one cycle between the last input and the next start acceptance.
- rst mid-frame aborts immediately: outputs go to reset values and partial results are discarded. No stale output is emitted after reset.

## Configuration
- MAXPOOL_RELU_EN defined: out_data = (result < 0) ? 0 : result. This is equivalent to ReLU-before-pool.
- MAXPOOL_RELU_EN undefined: out_data = result, with the sign preserved.
- Timing, latency and counts are identical in both builds.

## Test plan
- Ramp: start, then 676 samples in_data=r*26+c back-to-back. Expect 169 outputs, each (i,j)=26*(2i+1)+(2j+1); first (0,0)=27, last (12,12)=675. frame_done coincides with the last output and busy drops the cycle after.
- Negatives: every sample = -5 (20'hFFFFB). With MAXPOOL_RELU_EN, every out_data=0. Without it, every out_data=20'hFFFFB.
- Mixed signs: a 2x2 window {-100, 3, -1, 2} → out_data 3. Window {-7,-2,-9,-4} → -2 (unset) or 0 (set).
- Gappy input: drive in_valid randomly at about 40% duty with the ramp data. Outputs are identical to the ramp case, and each out_valid is exactly 1 cycle after its odd/odd accept.
- Control: in_valid asserted in IDLE before start produces no outputs and no counter movement. start pulsed mid-RUN is ignored and the output sequence is unchanged.
- Reset abort: assert rst after 300 samples. All outputs are 0 and busy=0. Then start a new full frame, which produces a correct 169-output result with no residue from the aborted frame.

Source files
------------

// File: rtl/maxpool_2x2_stream_if.sv
// Stream bundle for the 2x2 max-pool stage: conv samples in, pooled samples out.
interface maxpool_2x2_stream_if #(
  parameter int W  = 20,
  parameter int CW = 4
);
  logic          start;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          frame_done;
  logic          busy;

  modport master (
    output start, in_valid, in_data,
    input  out_valid, out_data, out_row, out_col, frame_done, busy
  );

  modport slave (
    input  start, in_valid, in_data,
    output out_valid, out_data, out_row, out_col, frame_done, busy
  );
endinterface

// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 stride-2 max-pool over a DIM x DIM raster, one-row line buffer.
// Define MAXPOOL_RELU_EN to clamp negative pooled results to zero.
module maxpool_2x2_stream #(
  parameter int DIM = 26,
  parameter int W   = 20,
  parameter int CW  = $clog2(DIM/2)
) (
  input  logic clk,
  input  logic rst,
  maxpool_2x2_stream_if.slave bus
);
  localparam int RW = $clog2(DIM);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [RW-1:0]        r, c, r_nxt, c_nxt;
  logic                 accept, last_px, emit;
  logic [CW-1:0]        half_c;
  logic signed [W-1:0]  x, h, lb_rd, cand, pooled;
  logic signed [W-1:0]  lb [DIM/2];

  logic          out_valid_q, frame_done_q;
  logic [W-1:0]  out_data_q;
  logic [CW-1:0] out_row_q, out_col_q;

  function automatic logic signed [W-1:0] smax(input logic signed [W-1:0] a,
                                               input logic signed [W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign x       = $signed(bus.in_data);
  assign accept  = (state == RUN) && bus.in_valid;
  assign last_px = (r == RW'(DIM-1)) && (c == RW'(DIM-1));
  assign emit    = accept && r[0] && c[0];
  assign half_c  = CW'(c >> 1);
  assign lb_rd   = lb[half_c];
  assign cand    = smax(h, x);

`ifdef MAXPOOL_RELU_EN
  assign pooled = (cand < 0) ? '0 : cand;
`else
  assign pooled = cand;
`endif

  always_comb begin
    state_nxt = state;
    r_nxt     = r;
    c_nxt     = c;
    case (state)
      IDLE: if (bus.start) begin
        state_nxt = RUN;
        r_nxt     = '0;
        c_nxt     = '0;
      end
      RUN: if (accept) begin
        if (last_px) begin
          state_nxt = DONE;
          r_nxt     = '0;
          c_nxt     = '0;
        end else if (c == RW'(DIM-1)) begin
          c_nxt = '0;
          r_nxt = r + 1'b1;
        end else begin
          c_nxt = c + 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      r     <= '0;
      c     <= '0;
    end else begin
      state <= state_nxt;
      r     <= r_nxt;
      c     <= c_nxt;
    end
  end

  // Even rows fold pairs into lb; odd rows fold lb back in and close the window.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (!r[0]) begin
        if (!c[0]) h <= x;
        else       lb[half_c] <= cand;
      end else if (!c[0]) begin
        h <= smax(lb_rd, x);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_data_q   <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
    end else begin
      out_valid_q  <= emit;
      frame_done_q <= accept && last_px;
      if (emit) begin
        out_data_q <= pooled;
        out_row_q  <= CW'(r >> 1);
        out_col_q  <= half_c;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_row    = out_row_q;
  assign bus.out_col    = out_col_q;
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Scoreboard bench for maxpool_2x2_stream: expected windows pushed at drive time, popped on out_valid.
module tb_maxpool_2x2_stream;
  localparam int DIM = 26;
  localparam int W   = 20;
  localparam int CW  = $clog2(DIM/2);
  localparam int HD  = DIM/2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  maxpool_2x2_stream_if #(.W(W), .CW(CW)) bus ();
  maxpool_2x2_stream #(.DIM(DIM), .W(W), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [W-1:0]  data;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic          last;
    int            cyc;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int n_checks = 0, n_pass = 0, cyc = 0, n_out = 0, n_fd = 0;
  logic signed [W-1:0] fm [DIM][DIM];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.frame_done) n_fd++;
    if (bus.out_valid) begin
      n_out++;
      n_checks++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_out: got out_valid row %0d col %0d data %h, required no output",
                 bus.out_row, bus.out_col, bus.out_data);
      end else begin
        me = q.pop_front();
        if (bus.out_data !== me.data || bus.out_row !== me.row || bus.out_col !== me.col ||
            bus.frame_done !== me.last || cyc !== me.cyc)
          $display("FAIL out_sample: got data %h row %0d col %0d fd %b cyc %0d, required data %h row %0d col %0d fd %b cyc %0d",
                   bus.out_data, bus.out_row, bus.out_col, bus.frame_done, cyc,
                   me.data, me.row, me.col, me.last, me.cyc);
        else n_pass++;
      end
    end else begin
      n_checks++;
      if (bus.frame_done !== 1'b0)
        $display("FAIL stray_frame_done: got %b without out_valid, required 0", bus.frame_done);
      else n_pass++;
    end
  end

  // Reference window max computed straight from the frame image.
  task automatic push_exp(input int r, input int c);
    logic signed [W-1:0] m;
    exp_t e;
    m = fm[r-1][c-1];
    if (fm[r-1][c] > m) m = fm[r-1][c];
    if (fm[r][c-1] > m) m = fm[r][c-1];
    if (fm[r][c]   > m) m = fm[r][c];
`ifdef MAXPOOL_RELU_EN
    if (m < 0) m = '0;
`endif
    e.data = m;
    e.row  = CW'(r/2);
    e.col  = CW'(c/2);
    e.last = (r == DIM-1) && (c == DIM-1);
    e.cyc  = cyc + 1;
    q.push_back(e);
  endtask

  task automatic fill(input int mode);
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        case (mode)
          0:       fm[r][c] = W'(r*DIM + c);
          1:       fm[r][c] = W'(-5);
          default: fm[r][c] = W'($urandom);
        endcase
    if (mode == 2) begin
      fm[0][0] = W'(-100); fm[0][1] = W'(3);  fm[1][0] = W'(-1); fm[1][1] = W'(2);
      fm[0][2] = W'(-7);   fm[0][3] = W'(-2); fm[1][2] = W'(-9); fm[1][3] = W'(-4);
      fm[2][0] = {1'b1, {(W-1){1'b0}}}; fm[2][1] = {1'b1, {(W-1){1'b0}}};
      fm[3][0] = {1'b1, {(W-1){1'b0}}}; fm[3][1] = {1'b1, {(W-1){1'b0}}};
      fm[2][2] = {1'b1, {(W-1){1'b0}}}; fm[2][3] = {1'b0, {(W-1){1'b1}}};
      fm[3][2] = W'(-1);                fm[3][3] = W'(0);
      fm[2][4] = W'(7); fm[2][5] = W'(7); fm[3][4] = W'(7); fm[3][5] = W'(7);
    end
  endtask

  // Called at #1 after a rising edge; returns at #1 after the edge accepting the last sample.
  task automatic drive_frame(input int duty, input int mid_start_at, input int stop_after);
    int r, c;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < stop_after; i++) begin
      while (duty < 100 && int'($urandom_range(99)) >= duty) begin
        bus.in_valid = 1'b0;
        bus.in_data  = W'($urandom);
        bus.start    = 1'b0;
        @(posedge clk); #1;
      end
      r = i / DIM;
      c = i % DIM;
      bus.in_valid = 1'b1;
      bus.in_data  = fm[r][c];
      bus.start    = (i == mid_start_at);
      if (r % 2 == 1 && c % 2 == 1) push_exp(r, c);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
  endtask

  task automatic run_full_frame(input string name, input int duty, input int mid_start_at);
    n_out = 0;
    n_fd  = 0;
    drive_frame(duty, mid_start_at, DIM*DIM);
    n_checks++;
    if (bus.busy !== 1'b1) $display("FAIL %s busy_in_done: got %b, required 1", name, bus.busy);
    else n_pass++;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL %s busy_after_done: got %b, required 0", name, bus.busy);
    else n_pass++;
    n_checks++;
    if (n_out != HD*HD) $display("FAIL %s out_count: got %0d, required %0d", name, n_out, HD*HD);
    else n_pass++;
    n_checks++;
    if (n_fd != 1) $display("FAIL %s frame_done_count: got %0d, required 1", name, n_fd);
    else n_pass++;
    n_checks++;
    if (q.size() != 0) $display("FAIL %s pending_expect: got %0d left, required 0", name, q.size());
    else n_pass++;
    q.delete();
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({bus.out_valid, bus.frame_done, bus.busy} !== 3'b000)
      $display("FAIL reset_flags: got vld %b fd %b busy %b, required 0 0 0",
               bus.out_valid, bus.frame_done, bus.busy);
    else n_pass++;
    n_checks++;
    if (bus.out_data !== '0 || bus.out_row !== '0 || bus.out_col !== '0)
      $display("FAIL reset_data: got data %h row %0d col %0d, required 0 0 0",
               bus.out_data, bus.out_row, bus.out_col);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ramp();        fill(0); run_full_frame("ramp", 100, -1);     endtask
  task automatic test_negatives();   fill(1); run_full_frame("negatives", 100, -1); endtask
  task automatic test_mixed_signs(); fill(2); run_full_frame("mixed", 100, -1);    endtask
  task automatic test_gappy();       fill(0); run_full_frame("gappy", 40, -1);     endtask

  task automatic test_control();
    fill(0);
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = W'($urandom);
      @(posedge clk); #1;
    end
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL control_idle_busy: got %b, required 0", bus.busy);
    else n_pass++;
    run_full_frame("control", 100, 100);
  endtask

  task automatic test_back_to_back();
    fill(2);
    run_full_frame("b2b_first", 100, -1);
    fill(0);
    run_full_frame("b2b_second", 100, -1);
  endtask

  task automatic test_reset_abort();
    fill(2);
    drive_frame(100, -1, 300);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.frame_done, bus.busy} !== 3'b000)
      $display("FAIL abort_flags: got vld %b fd %b busy %b, required 0 0 0",
               bus.out_valid, bus.frame_done, bus.busy);
    else n_pass++;
    n_checks++;
    if (bus.out_data !== '0 || bus.out_row !== '0 || bus.out_col !== '0)
      $display("FAIL abort_data: got data %h row %0d col %0d, required 0 0 0",
               bus.out_data, bus.out_row, bus.out_col);
    else n_pass++;
    n_checks++;
    if (q.size() != 0) $display("FAIL abort_pending: got %0d left, required 0", q.size());
    else n_pass++;
    q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    fill(0);
    run_full_frame("after_abort", 100, -1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    test_reset();
    test_ramp();
    test_negatives();
    test_mixed_signs();
    test_gappy();
    test_control();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
